rr_arbiter_4: RTL and testbench



---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_priority_encoder_4.sv | 34 +++
 rtl/rr_arbiter_4.sv | 111 +++++++++++
 tb/tb_rr_arbiter_4.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing for the four-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_encoder_4.sv
// Rotating priority encoder: first set request at or after ptr, wrapping mod 4.
module rr_priority_encoder_4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      rot_idx;

  // Doubling the vector turns the rotate-right into a plain part-select.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[{1'b0, ptr} +: NUM_REQ];

  always_comb begin
    found   = 1'b0;
    rot_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found   = 1'b1;
        rot_idx = ID_W'(i);
      end
    end
  end

  assign idx    = rot_idx + ptr;
  assign onehot = found ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with grant hold until release or hold-limit revoke.
//
//   state     | meaning
//   ARB_IDLE  | no owner; arbitrate among req starting at ptr
//   ARB_GRANT | one owner (grant_id); hold until release or hold limit
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                timeout_q, timeout_d;

  logic                enc_found;
  logic [ID_W-1:0]     enc_idx;
  logic [NUM_REQ-1:0]  enc_onehot;

  rr_priority_encoder_4 u_enc (
    .req    (req),
    .ptr    (ptr_q),
    .found  (enc_found),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    timeout_d  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (enc_found) begin
          state_d    = ARB_GRANT;
          grant_d    = enc_onehot;
          grant_id_d = enc_idx;
          ptr_d      = enc_idx + 2'd1;
          hold_cnt_d = CNT_ONE;
        end
      end
      ARB_GRANT: begin
        if (!req[grant_id_q]) begin
          state_d    = ARB_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          hold_cnt_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT)) begin
          // ptr already points past the owner, so it re-competes last.
          state_d    = ARB_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 (MAX_HOLD = 4) with a scoreboard queue.
module tb_rr_arbiter_4;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       to;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  bit       m_busy = 0;
  bit [1:0] m_ptr  = 0;
  int       m_hold = 0;
  bit [3:0] m_g    = 0;
  bit [1:0] m_id   = 0;
  bit       m_to   = 0;

  rr_arbiter_4 #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_update(input logic [3:0] r, input logic rn);
    bit [1:0] cand;
    bit       hit;
    if (!rn) begin
      m_busy = 0; m_ptr = 0; m_hold = 0; m_g = 0; m_id = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      hit  = 0;
      for (int k = 0; k < 4; k++) begin
        cand = m_ptr + 2'(k);
        if (!hit && r[cand]) begin
          hit    = 1;
          m_busy = 1;
          m_id   = cand;
          m_g    = 4'b0001 << cand;
          m_hold = 1;
        end
      end
      if (hit) m_ptr = m_id + 2'd1;
    end else begin
      m_to = 0;
      if (!r[m_id]) begin
        m_busy = 0; m_g = 0; m_id = 0; m_hold = 0;
      end else if (MH != 0 && m_hold == MH) begin
        m_busy = 0; m_g = 0; m_id = 0; m_hold = 0; m_to = 1;
      end else begin
        m_hold++;
      end
    end
  endtask

  // Drive one cycle of stimulus, push the expected outputs, then compare after the edge.
  task automatic step(input logic [3:0] r, input logic rn);
    exp_t e;
    req   = r;
    rst_n = rn;
    model_update(r, rn);
    e.g = m_g; e.id = m_id; e.v = (m_g != 0); e.to = m_to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v || timeout !== e.to) begin
      errors++;
      $display("FAIL scoreboard t=%0t: got grant=%b id=%0d valid=%b to=%b, expected grant=%b id=%0d valid=%b to=%b",
               $time, grant, grant_id, grant_valid, timeout, e.g, e.id, e.v, e.to);
    end
    checks++;
    if ($countones(grant) > 1 || grant_valid !== (|grant)) begin
      errors++;
      $display("FAIL onehot t=%0t: grant=%b valid=%b, required at most one bit and valid=OR(grant)",
               $time, grant, grant_valid);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0);
      checks++;
      if ({grant, grant_id, grant_valid, timeout} !== 8'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b, expected all zero", {grant, grant_id, grant_valid, timeout});
      end
    end
    step(4'b1111, 1'b1);
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant: got grant=%b id=%0d, expected grant=0001 id=0", grant, grant_id);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_single();
    bit saw_to = 0;
    step(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (grant !== 4'b0100 || grant_id !== 2'd2) begin
        errors++;
        $display("FAIL single_grant cycle %0d: got grant=%b id=%0d, expected grant=0100 id=2", i, grant, grant_id);
      end
      if (timeout) saw_to = 1;
      step((i < 2) ? 4'b0100 : 4'b0000, 1'b1);
    end
    if (timeout) saw_to = 1;
    checks++;
    if (grant !== 4'b0000 || saw_to) begin
      errors++;
      $display("FAIL single_release: got grant=%b timeout_seen=%b, expected grant=0000 timeout_seen=0", grant, saw_to);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    step(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step(4'b1111, 1'b1);
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL fair_grant round %0d: got grant=%b, expected %b", k, grant, exp_g);
      end
      step(4'b1111, 1'b1);
      step(4'b1111 & ~exp_g, 1'b1);
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL fair_bubble round %0d: got grant=%b, expected 0000", k, grant);
      end
    end
    step(4'b0000, 1'b1);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < MH; i++) begin
      step(4'b1010, 1'b1);
      checks++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold cycle %0d: got grant=%b to=%b, expected grant=0010 to=0", i, grant, timeout);
      end
    end
    step(4'b1010, 1'b1);
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_revoke: got grant=%b to=%b, expected grant=0000 to=1", grant, timeout);
    end
    step(4'b1010, 1'b1);
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_next_owner: got grant=%b id=%0d to=%b, expected grant=1000 id=3 to=0", grant, grant_id, timeout);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0100, 1'b1);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_bubble: got grant=%b, expected 0000", grant);
    end
    step(4'b0100, 1'b1);
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL b2b_new_owner: got grant=%b id=%0d, expected grant=0100 id=2", grant, grant_id);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid_grant();
    step(4'b1000, 1'b1);
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_setup: got grant=%b, expected 1000", grant);
    end
    step(4'b1001, 1'b0);
    checks++;
    if ({grant, grant_id, grant_valid, timeout} !== 8'b0) begin
      errors++;
      $display("FAIL midrst_clear: got %b, expected all zero", {grant, grant_id, grant_valid, timeout});
    end
    step(4'b1001, 1'b1);
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL midrst_ptr: got grant=%b id=%0d, expected grant=0001 id=0", grant, grant_id);
    end
    step(4'b0000, 1'b1);
  endtask

  initial begin
    req   = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_back_to_back();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
